// File: rtl/yolo_sif_pkg.sv
// Shared constants for the yolo stream-interface FIFO.
// Entries are packed as {last, user, strb, data}.
package yolo_sif_pkg;

    localparam int unsigned SIF_TBITS    = 32;
    localparam int unsigned SIF_TBYTE    = SIF_TBITS / 8;
    localparam int unsigned SIF_ENTRY_W  = SIF_TBITS + SIF_TBYTE + 2;

    // Field offsets inside the packed entry at the default widths
    localparam int unsigned SIF_DATA_LSB = 0;
    localparam int unsigned SIF_STRB_LSB = SIF_TBITS;
    localparam int unsigned SIF_USER_BIT = SIF_TBITS + SIF_TBYTE;
    localparam int unsigned SIF_LAST_BIT = SIF_TBITS + SIF_TBYTE + 1;

    // Entry width for a non-default beat width
    function automatic int unsigned sif_entry_w(input int unsigned tbits,
                                                input int unsigned tbyte);
        return tbits + tbyte + 2;
    endfunction

endpackage

// File: rtl/yolo_sif_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module yolo_sif_ram #(
    parameter int unsigned WIDTH = 38,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store an accepted beat at the write pointer
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/yolo_sif_fifo.sv
// Stream-interface FIFO between a producer (osif-style write side) and a
// consumer (isif-style first-word-fall-through read side).
// Optional sticky overflow/underflow flags: define YOLO_SIF_FIFO_ERR_EN.
module yolo_sif_fifo
    import yolo_sif_pkg::*;
#(
    parameter int unsigned TBITS = SIF_TBITS,
    parameter int unsigned TBYTE = SIF_TBYTE,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TBITS-1:0] sif_data_din,
    input  logic [TBYTE-1:0] sif_strb_din,
    input  logic             sif_last_din,
    input  logic             sif_user_din,
    input  logic             sif_write,
    output logic             sif_full_n,
    output logic [TBITS-1:0] sif_data_dout,
    output logic [TBYTE-1:0] sif_strb_dout,
    output logic             sif_last_dout,
    output logic             sif_user_dout,
    output logic             sif_empty_n,
    input  logic             sif_read,
    output logic [AW:0]      sif_level,
    output logic [1:0]       sif_err
);

    localparam int unsigned EntryW  = sif_entry_w(TBITS, TBYTE);
    localparam int unsigned StrbLsb = TBITS;
    localparam int unsigned UserBit = TBITS + TBYTE;
    localparam int unsigned LastBit = TBITS + TBYTE + 1;
    localparam logic [AW:0] LevelFull = (AW+1)'(DEPTH);

    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       level_q, level_d;
    logic              full_n_q, empty_n_q;
    logic              wr_ok, rd_ok;
    logic [EntryW-1:0] wr_entry, rd_entry;

    assign wr_ok    = sif_write & full_n_q;
    assign rd_ok    = sif_read & empty_n_q;
    assign wr_entry = {sif_last_din, sif_user_din, sif_strb_din, sif_data_din};

    yolo_sif_ram #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr_q),
        .wdata (wr_entry),
        .raddr (rptr_q),
        .rdata (rd_entry)
    );

    // Occupancy next state: simultaneous accepted push and pop cancel out
    always_comb begin
        level_d = level_q;
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointers, level and flags; flags come from next-state level so they are
    // valid the cycle after the event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + AW'(1);
            if (rd_ok) rptr_q <= rptr_q + AW'(1);
            level_q   <= level_d;
            full_n_q  <= (level_d != LevelFull);
            empty_n_q <= (level_d != '0);
        end
    end

    assign sif_full_n  = full_n_q;
    assign sif_empty_n = empty_n_q;
    assign sif_level   = level_q;

    // Head entry falls through; stale storage is masked while empty
    always_comb begin
        sif_data_dout = '0;
        sif_strb_dout = '0;
        sif_user_dout = 1'b0;
        sif_last_dout = 1'b0;
        if (empty_n_q) begin
            sif_data_dout = rd_entry[TBITS-1:0];
            sif_strb_dout = rd_entry[StrbLsb +: TBYTE];
            sif_user_dout = rd_entry[UserBit];
            sif_last_dout = rd_entry[LastBit];
        end
    end

`ifdef YOLO_SIF_FIFO_ERR_EN
    logic [1:0] err_q;

    // Sticky overflow (bit 0) and underflow (bit 1), cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | {sif_read & ~empty_n_q, sif_write & ~full_n_q};
        end
    end

    assign sif_err = err_q;
`else
    assign sif_err = 2'b00;
`endif

endmodule

// File: tb/tb_yolo_sif_fifo.sv
// Self-checking bench for yolo_sif_fifo: directed cases plus randomized
// traffic against a queue-based reference model.
module tb_yolo_sif_fifo;

    localparam int unsigned TBITS = 32;
    localparam int unsigned TBYTE = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    typedef logic [TBITS+TBYTE+1:0] entry_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [TBITS-1:0] sif_data_din;
    logic [TBYTE-1:0] sif_strb_din;
    logic             sif_last_din;
    logic             sif_user_din;
    logic             sif_write;
    logic             sif_full_n;
    logic [TBITS-1:0] sif_data_dout;
    logic [TBYTE-1:0] sif_strb_dout;
    logic             sif_last_dout;
    logic             sif_user_dout;
    logic             sif_empty_n;
    logic             sif_read;
    logic [AW:0]      sif_level;
    logic [1:0]       sif_err;

    entry_t     model_q[$];
    logic [1:0] exp_err;
    int         n_tests = 0;
    int         n_fail  = 0;

    yolo_sif_fifo #(
        .TBITS (TBITS),
        .TBYTE (TBYTE),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sif_data_din  (sif_data_din),
        .sif_strb_din  (sif_strb_din),
        .sif_last_din  (sif_last_din),
        .sif_user_din  (sif_user_din),
        .sif_write     (sif_write),
        .sif_full_n    (sif_full_n),
        .sif_data_dout (sif_data_dout),
        .sif_strb_dout (sif_strb_dout),
        .sif_last_dout (sif_last_dout),
        .sif_user_dout (sif_user_dout),
        .sif_empty_n   (sif_empty_n),
        .sif_read      (sif_read),
        .sif_level     (sif_level),
        .sif_err       (sif_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the reference queue
    task automatic check_model(input string tag);
        entry_t head;
        int     sz;
        sz   = model_q.size();
        head = (sz != 0) ? model_q[0] : '0;
        check({tag, ".level"},   64'(sif_level),     64'(sz));
        check({tag, ".full_n"},  64'(sif_full_n),    64'(sz != DEPTH));
        check({tag, ".empty_n"}, 64'(sif_empty_n),   64'(sz != 0));
        check({tag, ".data"},    64'(sif_data_dout), 64'(head[TBITS-1:0]));
        check({tag, ".strb"},    64'(sif_strb_dout), 64'(head[TBITS +: TBYTE]));
        check({tag, ".user"},    64'(sif_user_dout), 64'(head[TBITS+TBYTE]));
        check({tag, ".last"},    64'(sif_last_dout), 64'(head[TBITS+TBYTE+1]));
        check({tag, ".err"},     64'(sif_err),       64'(exp_err));
    endtask

    // One clock with the given request; called and returns #1 after a rising edge
    task automatic cycle(input string tag, input logic w, input logic [TBITS-1:0] d,
                         input logic [TBYTE-1:0] s, input logic l, input logic u,
                         input logic r);
        bit     can_w, can_r;
        entry_t dropped;
        sif_write    = w;
        sif_data_din = d;
        sif_strb_din = s;
        sif_last_din = l;
        sif_user_din = u;
        sif_read     = r;
        can_w = w && (model_q.size() < DEPTH);
        can_r = r && (model_q.size() > 0);
`ifdef YOLO_SIF_FIFO_ERR_EN
        if (w && !can_w) exp_err[0] = 1'b1;
        if (r && model_q.size() == 0) exp_err[1] = 1'b1;
`endif
        @(posedge clk);
        #1;
        if (can_r) dropped = model_q.pop_front();
        if (can_w) model_q.push_back({l, u, s, d});
        sif_write = 1'b0;
        sif_read  = 1'b0;
        check_model(tag);
    endtask

    task automatic wr(input string tag, input logic [TBITS-1:0] d);
        cycle(tag, 1'b1, d, 4'hF, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input string tag);
        cycle(tag, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_q.delete();
        exp_err = 2'b00;
        check_model({tag, ".async"});
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_model({tag, ".after"});
    endtask

    logic [1:0] ovf_exp;

    initial begin
        sif_write    = 1'b0;
        sif_read     = 1'b0;
        sif_data_din = '0;
        sif_strb_din = '0;
        sif_last_din = 1'b0;
        sif_user_din = 1'b0;
        exp_err      = 2'b00;
        rst          = 1'b0;
        #2;
        do_reset("reset");
        check("reset.full_n", 64'(sif_full_n), 64'd1);
        check("reset.data", 64'(sif_data_dout), 64'd0);
        rd("idle_underflow");

        // Single beat, first-word latency of one cycle
        do_reset("rst1");
        cycle("single.wr", 1'b1, 32'h0000_1234, 4'hF, 1'b1, 1'b0, 1'b0);
        check("single.empty_n", 64'(sif_empty_n), 64'd1);
        check("single.dout", 64'(sif_data_dout), 64'h1234);
        check("single.last", 64'(sif_last_dout), 64'd1);
        rd("single.rd");
        check("single.level0", 64'(sif_level), 64'd0);

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) wr("fill", 32'(i));
        check("fill.full_n", 64'(sif_full_n), 64'd0);
        check("fill.level", 64'(sif_level), 64'd16);
        wr("overflow", 32'hDEAD);
`ifdef YOLO_SIF_FIFO_ERR_EN
        ovf_exp = 2'b01;
`else
        ovf_exp = 2'b00;
`endif
        check("overflow.err0", 64'(sif_err[0]), 64'(ovf_exp[0]));
        check("overflow.level", 64'(sif_level), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check("drain.order", 64'(sif_data_dout), 64'(i));
            rd("drain");
        end

        // Simultaneous read/write at full and at empty
        for (int i = 0; i < 16; i++) wr("refill", 32'(i));
        cycle("full.rw", 1'b1, 32'hAA, 4'hF, 1'b0, 1'b0, 1'b1);
        check("full.rw.level", 64'(sif_level), 64'd15);
        check("full.rw.head", 64'(sif_data_dout), 64'd1);
        for (int i = 0; i < 15; i++) rd("full.rw.drain");
        cycle("empty.rw", 1'b1, 32'hAA, 4'hF, 1'b0, 1'b0, 1'b1);
        check("empty.rw.level", 64'(sif_level), 64'd1);
        check("empty.rw.head", 64'(sif_data_dout), 64'hAA);
        rd("empty.rw.drain");

        // Streaming with pointer wrap, level held at 1
        wr("stream.prime", 32'h100);
        for (int i = 1; i < 40; i++) begin
            check("stream.order", 64'(sif_data_dout), 64'(32'h100 + i - 1));
            cycle("stream", 1'b1, 32'(32'h100 + i), 4'hF, 1'b0, 1'b1, 1'b1);
            check("stream.level", 64'(sif_level), 64'd1);
        end
        rd("stream.tail");

        // Reset mid-packet
        for (int i = 0; i < 5; i++) wr("pkt", 32'(32'h200 + i));
        do_reset("midpkt");
        check("midpkt.empty_n", 64'(sif_empty_n), 64'd0);
        wr("post.wr", 32'h55);
        check("post.first", 64'(sif_data_dout), 64'h55);
        rd("post.rd");

        // Randomized traffic with varying bias and rare resets
        for (int blk = 0; blk < 15; blk++) begin
            int unsigned pw, pr;
            pw = $urandom_range(10, 95);
            pr = $urandom_range(10, 95);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 499) == 0) begin
                    do_reset("rand.rst");
                end else begin
                    cycle("rand", 1'($urandom_range(0, 99) < pw), 32'($urandom),
                          4'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom_range(0, 99) < pr));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/yolo_sif_fifo.md
Name: yolo_sif_fifo

Overview:
- Stream-interface FIFO that owns the other end of the yolo_core stream ports.
- Write side is driven by a producer with the osif_* signal set (din, strb, last, user, write; returns full_n).
- Read side presents the isif_* signal set (dout, strb, last, user, empty_n; accepts read) to a consumer such as yolo_core.
- Instanced on both sides of the core: host-to-core feeds isif; core-to-host drains osif.

Parameters:
- TBITS, 32, data beat width.
- TBYTE, 4, strobe width (TBITS/8).
- DEPTH, 16, number of entries; power of two, at least 2.
- AW, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sif_data_din  in  TBITS  write data.
- sif_strb_din  in  TBYTE  write byte strobes.
- sif_last_din  in  1  write end-of-packet flag.
- sif_user_din  in  1  write user flag.
- sif_write  in  1  write request.
- sif_full_n  out  1  high when an entry is free.
- sif_data_dout  out  TBITS  head-entry data.
- sif_strb_dout  out  TBYTE  head-entry strobes.
- sif_last_dout  out  1  head-entry last flag.
- sif_user_dout  out  1  head-entry user flag.
- sif_empty_n  out  1  high when the head entry is valid.
- sif_read  in  1  pop request.
- sif_level  out  AW+1  current occupancy, 0..DEPTH.
- sif_err  out  2  bit0 = overflow sticky, bit1 = underflow sticky (see Optional Feature).

Behaviour:
- Entry format: stored packed as {last, user, strb, data}, width TBITS+TBYTE+2.
- Reset, asynchronous on rst high:
  - wptr=0, rptr=0, level=0.
  - sif_full_n=1, sif_empty_n=0, sif_err=0.
  - dout fields drive 0 while empty.
  - Storage contents are not reset.
- Read mode is first-word-fall-through: dout fields are combinational from mem[rptr] while sif_empty_n=1, and 0 otherwise.
- Write acceptance: wr_ok = sif_write & sif_full_n. An accepted write stores the beat at mem[wptr] on the clock edge, then wptr increments.
- Read acceptance: rd_ok = sif_read & sif_empty_n. An accepted read increments rptr on the clock edge.
- Level update: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither occur.
- Flags:
  - sif_empty_n = (level != 0), registered.
  - sif_full_n = (level != DEPTH), registered.
  - Both flags are derived from the next-state level so they are valid the cycle after the event.
- Latency: a write at edge N into an empty FIFO raises sif_empty_n and shows the data after edge N; first-word latency is 1 cycle.
- Pointers wrap modulo DEPTH naturally; level is AW+1 bits to distinguish full from empty.
- Boundary cases:
  - Empty plus simultaneous write and read: the read is ignored (empty_n=0); the write is accepted; level becomes 1.
  - Full plus simultaneous write and read: the write is ignored (full_n=0); the read is accepted; level becomes DEPTH-1.
  - Write while full_n=0: the beat is dropped; no state change except the overflow flag.
  - Read while empty_n=0: no state change except the underflow flag.
  - Reset mid-packet discards all content; no partial packet survives.
- Throughput: one write and one read per cycle sustained when 0 < level < DEPTH.

Optional Feature:
- Macro: YOLO_SIF_FIFO_ERR_EN.
- Defined:
  - sif_err[0] sets on sif_write & ~sif_full_n.
  - sif_err[1] sets on sif_read & ~sif_empty_n.
  - Both bits are sticky until rst.
- Undefined: sif_err is tied to 2'b00 and the port remains so the interface is stable; no error logic is generated.

Decomposition:
- Package yolo_sif_pkg holds:
  - Default TBITS/TBYTE.
  - Entry-width constant (TBITS+TBYTE+2).
  - Field offset constants for last/user/strb/data in the packed entry.
- Sub-module yolo_sif_ram: DEPTH x entry register array with one synchronous write port and one asynchronous read port. Pointer, level and flag logic stay in yolo_sif_fifo.

Test Plan:
- Reset then idle: sif_full_n=1, sif_empty_n=0, sif_level=0, sif_data_dout=0, sif_err=0.
- Single beat: write data=0x0000_1234, strb=4'hF, last=1 at edge N. After edge N: empty_n=1, dout=0x1234, last_dout=1. Read one cycle, then empty_n=0, level=0.
- Fill and overflow:
  - 16 writes of 0..15 give full_n=0, level=16.
  - A 17th write of 0xDEAD is dropped; err[0]=1 with macro, 0 without.
  - Draining returns 0..15 in order.
- Simultaneous read and write:
  - At level=16, one cycle of write 0xAA plus read pops 0 and gives level=15 with 0xAA not stored.
  - At level=0, the same stimulus stores 0xAA and gives level=1.
- Streaming and wrap: 40 beats written and read concurrently every cycle give 40 beats out in order with level staying at 1, exercising pointer wrap twice.
- Reset mid-packet: write 5 beats, assert rst for 1 cycle, then empty_n=0, level=0, err=0. The next write 0x55 is the first output.
